// File: rtl/dsu_halt_controller.sv
// dsu_halt_controller: Debug Support Unit halt sequencer.
// Watches per-thread instruction issue, matches it against the breakpoint list or
// single-step mode, stops threads and reports the hit until a resume pulse.
// Optional feature macro: DSU_HALT_ALL_ON_HIT_EN (stop every thread on a hit instead
// of only the reported one).
module dsu_halt_controller #(
    parameter int THREAD_NUMB  = 8,
    parameter int BP_NUMB      = 8,
    parameter int ADDRESS_SIZE = 32
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                dsu_enable,
    input  logic                                dsu_breakpoint_enable,
    input  logic [BP_NUMB*ADDRESS_SIZE-1:0]     dsu_breakpoint,
    input  logic                                dsu_single_step,
    input  logic                                dsu_thread_selection,
    input  logic [$clog2(THREAD_NUMB)-1:0]      dsu_thread_id,
    input  logic                                dsu_resume_core,
    input  logic [THREAD_NUMB-1:0]              issue_valid,
    input  logic [THREAD_NUMB*ADDRESS_SIZE-1:0] issue_pc,
    output logic [THREAD_NUMB-1:0]              thread_stop,
    output logic                                dsu_hit_breakpoint,
    output logic [$clog2(THREAD_NUMB)-1:0]      dsu_bp_thread_id,
    output logic [THREAD_NUMB*ADDRESS_SIZE-1:0] dsu_bp_instruction
);

    localparam int TID_W = $clog2(THREAD_NUMB);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        HALT_REPORT,
        HALTED,
        RESUMING
    } state_t;

    state_t                                state_q, state_d;
    logic [THREAD_NUMB-1:0]                thread_stop_q, thread_stop_d;
    logic                                  hit_q, hit_d;
    logic [TID_W-1:0]                      bp_tid_q, bp_tid_d;
    logic [THREAD_NUMB*ADDRESS_SIZE-1:0]   bp_instr_q, bp_instr_d;

    logic [THREAD_NUMB-1:0]                eligible;
    logic [THREAD_NUMB-1:0]                bp_match;
    logic [THREAD_NUMB-1:0]                thread_hit;
    logic [TID_W-1:0]                      hit_id;
    logic [THREAD_NUMB-1:0]                stop_mask;

    // Per-thread eligibility, breakpoint compare and lowest-index hit selection.
    always_comb begin
        eligible   = '0;
        bp_match   = '0;
        thread_hit = '0;
        hit_id     = '0;
        for (int t = 0; t < THREAD_NUMB; t++) begin
            eligible[t] = issue_valid[t] && !thread_stop_q[t] &&
                          (!dsu_thread_selection || (dsu_thread_id == TID_W'(t)));
            // An all-ones PC is the unused-slot marker, so it can never match.
            if (dsu_breakpoint_enable &&
                (issue_pc[t*ADDRESS_SIZE +: ADDRESS_SIZE] != {ADDRESS_SIZE{1'b1}})) begin
                for (int b = 0; b < BP_NUMB; b++) begin
                    if (issue_pc[t*ADDRESS_SIZE +: ADDRESS_SIZE] ==
                        dsu_breakpoint[b*ADDRESS_SIZE +: ADDRESS_SIZE]) begin
                        bp_match[t] = 1'b1;
                    end
                end
            end
            thread_hit[t] = eligible[t] && (bp_match[t] || dsu_single_step);
        end
        // Scan downwards so the lowest hitting index is the one left in hit_id.
        for (int t = THREAD_NUMB - 1; t >= 0; t--) begin
            if (thread_hit[t]) begin
                hit_id = TID_W'(t);
            end
        end
`ifdef DSU_HALT_ALL_ON_HIT_EN
        stop_mask = '1;
`else
        stop_mask = THREAD_NUMB'(1) << hit_id;
`endif
    end

    // Halt sequencing FSM next state, stop mask, hit pulse and reported thread.
    always_comb begin
        state_d       = state_q;
        thread_stop_d = thread_stop_q;
        hit_d         = 1'b0;
        bp_tid_d      = bp_tid_q;
        case (state_q)
            IDLE: begin
                thread_stop_d = '0;
                if (dsu_enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (|thread_hit) begin
                    state_d       = HALT_REPORT;
                    thread_stop_d = stop_mask;
                    hit_d         = 1'b1;
                    bp_tid_d      = hit_id;
                end
            end
            HALT_REPORT: begin
                state_d = HALTED;
            end
            HALTED: begin
                if (dsu_resume_core) begin
                    state_d = RESUMING;
                end
            end
            RESUMING: begin
                thread_stop_d = '0;
                state_d       = RUN;
            end
            default: begin
                state_d       = IDLE;
                thread_stop_d = '0;
            end
        endcase
        // Disabling the DSU overrides everything; the reported thread and PCs are kept.
        if (!dsu_enable) begin
            state_d       = IDLE;
            thread_stop_d = '0;
            hit_d         = 1'b0;
        end
    end

    // Track the last eligible issued PC per thread, frozen while halted.
    always_comb begin
        bp_instr_d = bp_instr_q;
        if (state_q != HALTED) begin
            for (int t = 0; t < THREAD_NUMB; t++) begin
                if (eligible[t]) begin
                    bp_instr_d[t*ADDRESS_SIZE +: ADDRESS_SIZE] =
                        issue_pc[t*ADDRESS_SIZE +: ADDRESS_SIZE];
                end
            end
        end
    end

    // State and output registers; reset releases every stop immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            thread_stop_q <= '0;
            hit_q         <= 1'b0;
            bp_tid_q      <= '0;
            bp_instr_q    <= '0;
        end else begin
            state_q       <= state_d;
            thread_stop_q <= thread_stop_d;
            hit_q         <= hit_d;
            bp_tid_q      <= bp_tid_d;
            bp_instr_q    <= bp_instr_d;
        end
    end

    assign thread_stop        = thread_stop_q;
    assign dsu_hit_breakpoint = hit_q;
    assign dsu_bp_thread_id   = bp_tid_q;
    assign dsu_bp_instruction = bp_instr_q;

endmodule
